// File: rtl/fight_pkg.sv
// Shared fight-game definitions: action codes and the turn-sequencer state enum,
// used by the sequencer and the player FSMs alike.
package fight_pkg;

  typedef logic [2:0] action_t;

  localparam action_t ACT_KICK   = 3'b000;
  localparam action_t ACT_PUNCH  = 3'b001;
  localparam action_t ACT_AWAIT  = 3'b010;
  localparam action_t ACT_JUMP   = 3'b011;
  localparam action_t ACT_LEFT1  = 3'b100;
  localparam action_t ACT_LEFT2  = 3'b101;
  localparam action_t ACT_RIGHT1 = 3'b110;
  localparam action_t ACT_RIGHT2 = 3'b111;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    SETTLE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/turn_timer.sv
// Collect-phase timeout counter: counts up from 0 while neither cleared nor held and
// flags expiry once it reaches TURN_TIMEOUT-1, where it stays until cleared.
module turn_timer #(
  parameter int TURN_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic expired
);

  localparam int CW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TURN_TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (!hold && count_reg != LAST) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/turn_sequencer.sv
// Two-player turn sequencer: collects one action per player, then issues a step pulse.
// Optional collect timeout (await fill) is enabled by defining TURN_SEQUENCER_TIMEOUT_EN.
module turn_sequencer
  import fight_pkg::*;
#(
  parameter int TURN_TIMEOUT = 200,
  parameter int TURN_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p1_valid,
  input  logic [2:0]        p1_action,
  output logic              p1_ready,
  input  logic              p2_valid,
  input  logic [2:0]        p2_action,
  output logic              p2_ready,
  input  logic              game_over,
  output logic              step,
  output logic [2:0]        action1,
  output logic [2:0]        action2,
  output logic [TURN_W-1:0] turn_count
);

  if (TURN_TIMEOUT < 1) begin : g_bad_timeout
    $error("turn_sequencer: TURN_TIMEOUT must be at least 1");
  end

  seq_state_t        state_reg;
  logic [1:0]        full_reg;
  action_t           slot_reg [2];
  logic              step_reg;
  action_t           action1_reg;
  action_t           action2_reg;
  logic [TURN_W-1:0] turn_count_reg;

  logic [1:0] valid_vec;
  logic [1:0] ready_vec;
  logic [1:0] xfer_vec;
  logic [1:0] fill_vec;
  logic [1:0] full_next;
  action_t    act_in [2];
  action_t    slot_next [2];

  assign valid_vec = {p2_valid, p1_valid};
  assign act_in[0] = p1_action;
  assign act_in[1] = p2_action;

`ifdef TURN_SEQUENCER_TIMEOUT_EN
  logic expired;

  // Timer runs only while collecting; game_over freezes it where it stands.
  turn_timer #(
    .TURN_TIMEOUT(TURN_TIMEOUT)
  ) u_turn_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg != COLLECT),
    .hold   (game_over),
    .expired(expired)
  );
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    assign ready_vec[gi] = (state_reg == COLLECT) && !full_reg[gi] && !game_over;
    assign xfer_vec[gi]  = valid_vec[gi] && ready_vec[gi];
`ifdef TURN_SEQUENCER_TIMEOUT_EN
    // A genuine transfer in the expiry cycle wins over the await fill.
    assign fill_vec[gi]  = (state_reg == COLLECT) && expired && !game_over &&
                           !full_reg[gi] && !xfer_vec[gi];
`else
    assign fill_vec[gi]  = 1'b0;
`endif
    assign slot_next[gi] = xfer_vec[gi] ? act_in[gi] :
                           (fill_vec[gi] ? ACT_AWAIT : slot_reg[gi]);
    assign full_next[gi] = full_reg[gi] || xfer_vec[gi] || fill_vec[gi];
  end

  // Outputs for the turn are loaded on the edge that completes collection,
  // so step and the actions appear together in the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= COLLECT;
      full_reg       <= '0;
      slot_reg[0]    <= ACT_AWAIT;
      slot_reg[1]    <= ACT_AWAIT;
      step_reg       <= 1'b0;
      action1_reg    <= ACT_AWAIT;
      action2_reg    <= ACT_AWAIT;
      turn_count_reg <= '0;
    end else begin
      step_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          full_reg    <= full_next;
          slot_reg[0] <= slot_next[0];
          slot_reg[1] <= slot_next[1];
          if ((&full_next) && !game_over) begin
            state_reg      <= ISSUE;
            step_reg       <= 1'b1;
            action1_reg    <= slot_next[0];
            action2_reg    <= slot_next[1];
            turn_count_reg <= turn_count_reg + 1'b1;
          end
        end
        ISSUE: begin
          state_reg <= SETTLE;
        end
        SETTLE: begin
          full_reg  <= '0;
          state_reg <= COLLECT;
        end
        default: begin
          full_reg  <= '0;
          state_reg <= COLLECT;
        end
      endcase
    end
  end

  assign p1_ready   = ready_vec[0];
  assign p2_ready   = ready_vec[1];
  assign step       = step_reg;
  assign action1    = action1_reg;
  assign action2    = action2_reg;
  assign turn_count = turn_count_reg;

endmodule
